median_line_buffer: RTL

//   Streaming 3-row line buffer in front of the median filter's Sorting_network stage.
//   - Input: raster-order pixels.
//   - Output: one vertical 3-pixel column per accepted pixel, on S1/S2/S3.
//   - S1 = row r-2, S2 = row r-1, S3 = row r, all from the same column.
//   - Downstream sorting stages build the 3x3 median from consecutive columns.

---
 rtl/median_line_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/median_line_buffer.sv
// Three-row line buffer feeding the median sorting network: one vertical column per pixel.
// Optional `LINEBUF_ZERO_FILL_EN emits rows 0/1 with missing rows driven to zero.
module median_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sof,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_S1,
  output logic [DATA_WIDTH-1:0] o_S2,
  output logic [DATA_WIDTH-1:0] o_S3,
  output logic [COL_W-1:0]      o_col
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_COL = AW'(IMG_WIDTH - 1);

  logic [AW-1:0]         r_colCnt;
  logic [1:0]            r_rowCnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_S1;
  logic [DATA_WIDTH-1:0] r_S2;
  logic [DATA_WIDTH-1:0] r_S3;
  logic [COL_W-1:0]      r_col;

  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];

  logic [AW-1:0]         w_colEff;
  logic [1:0]            w_rowEff;
  logic [AW-1:0]         w_colNext;
  logic [1:0]            w_rowNext;
  logic [DATA_WIDTH-1:0] w_lb0Rd;
  logic [DATA_WIDTH-1:0] w_lb1Rd;
  logic [DATA_WIDTH-1:0] w_S1Next;
  logic [DATA_WIDTH-1:0] w_S2Next;
  logic                  w_validNext;

  // A start-of-frame beat is treated as row 0 / col 0 regardless of the counters.
  always_comb begin
    w_colEff  = i_sof ? '0 : r_colCnt;
    w_rowEff  = i_sof ? 2'd0 : r_rowCnt;
    w_lb0Rd   = r_lb0[w_colEff];
    w_lb1Rd   = r_lb1[w_colEff];
    w_colNext = w_colEff + AW'(1);
    w_rowNext = w_rowEff;
    if (w_colEff == LAST_COL) begin
      w_colNext = '0;
      w_rowNext = (w_rowEff == 2'd2) ? 2'd2 : w_rowEff + 2'd1;
    end
`ifdef LINEBUF_ZERO_FILL_EN
    w_S1Next    = (w_rowEff == 2'd2) ? w_lb0Rd : '0;
    w_S2Next    = (w_rowEff != 2'd0) ? w_lb1Rd : '0;
    w_validNext = 1'b1;
`else
    w_S1Next    = w_lb0Rd;
    w_S2Next    = w_lb1Rd;
    w_validNext = (w_rowEff == 2'd2);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_colCnt <= '0;
      r_rowCnt <= 2'd0;
      r_valid  <= 1'b0;
      r_S1     <= '0;
      r_S2     <= '0;
      r_S3     <= '0;
      r_col    <= '0;
    end else if (i_valid) begin
      r_colCnt <= w_colNext;
      r_rowCnt <= w_rowNext;
      r_valid  <= w_validNext;
      r_S1     <= w_S1Next;
      r_S2     <= w_S2Next;
      r_S3     <= i_data;
      r_col    <= COL_W'(w_colEff);
    end else begin
      r_valid  <= 1'b0;
    end
  end

  // Line RAM is never cleared; stale rows are masked by the row counter.
  always_ff @(posedge clk) begin
    if (!rst && i_valid) begin
      r_lb0[w_colEff] <= w_lb1Rd;
      r_lb1[w_colEff] <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_S1    = r_S1;
  assign o_S2    = r_S2;
  assign o_S3    = r_S3;
  assign o_col   = r_col;

endmodule
